// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the hazard controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_HALT      = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an IF/ID source that reads the register an ID/EX load is writing.
module hazard_cmp #(
  parameter int REG_W    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             valid,
  input  logic             memread,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output logic             hazard
);

  logic match;
  logic rd_zero;

  assign match   = (rd == rs) || (rd == rt);
  assign rd_zero = (rd == '0);
  // A hard-wired zero register never carries a real dependency.
  assign hazard  = valid && memread && match && !(ZERO_REG && rd_zero);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, halt, memory freeze and stall counting.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int              OP_W     = 4,
  parameter int              REG_W    = 4,
  parameter logic [OP_W-1:0] HLT_OP   = OP_W'(OP_HLT),
  parameter int              LOAD_LAT = 1,
  parameter bit              ZERO_REG = 1'b1,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [OP_W-1:0]  if_id_opcode,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             stall,
  output logic             if_id_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              WC_W      = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int              WAIT_INIT = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;

  hz_state_t        state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;
  logic             halt_op;

  hazard_cmp #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_cmp (
    .valid   (if_id_valid),
    .memread (id_ex_memread),
    .rs      (if_id_rs),
    .rt      (if_id_rt),
    .rd      (id_ex_rd),
    .hazard  (hazard)
  );

  assign halt_op = if_id_valid && (if_id_opcode == HLT_OP);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    stall       = 1'b0;
    if_id_flush = 1'b0;
    if (state_q == ST_HALT) begin
      stall = 1'b1;
    end else if (!mem_ready) begin
      // Memory not done: everything holds, including the load-wait countdown.
      state_d = state_q;
    end else if (branch_taken) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      stall       = 1'b1;
      state_d     = ST_RUN;
      wait_d      = '0;
    end else if (state_q == ST_LOAD_WAIT) begin
      stall = 1'b1;
      if (wait_q == '0) state_d = ST_RUN;
      else              wait_d  = wait_q - 1'b1;
    end else if (halt_op) begin
      stall   = 1'b1;
      state_d = ST_HALT;
    end else if (hazard) begin
      // The first bubble is issued from RUN; LOAD_WAIT covers the remaining LOAD_LAT-1.
      stall = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = ST_LOAD_WAIT;
        wait_d  = WC_W'(WAIT_INIT);
      end
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall && !if_id_flush && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign halted    = (state_q == ST_HALT);
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: instance A uses LOAD_LAT=1, instance B uses LOAD_LAT=3 with a 4-bit counter.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00100;
  localparam logic [4:0] C_FLUSH  = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_HALT   = 5'b00101;
  localparam logic       A = 1'b0;
  localparam logic       B = 1'b1;

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
    logic       mr;
    logic       rdy;
    logic       br;
    logic       sel;
    logic [4:0] ctl;
    logic [15:0] cnt;
  } step_t;

  typedef struct {
    logic        sel;
    logic [4:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_id_valid;
  logic [3:0] if_id_opcode, if_id_rs, if_id_rt, id_ex_rd;
  logic       id_ex_memread, mem_ready, branch_taken;
  logic       pc_write_a, if_id_write_a, stall_a, if_id_flush_a, halted_a;
  logic       pc_write_b, if_id_write_b, stall_b, if_id_flush_b, halted_b;
  logic [15:0] stall_cnt_a;
  logic [3:0]  stall_cnt_b;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .pc_write(pc_write_a),
    .if_id_write(if_id_write_a), .stall(stall_a), .if_id_flush(if_id_flush_a),
    .halted(halted_a), .stall_cnt(stall_cnt_a)
  );

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .pc_write(pc_write_b),
    .if_id_write(if_id_write_b), .stall(stall_b), .if_id_flush(if_id_flush_b),
    .halted(halted_b), .stall_cnt(stall_cnt_b)
  );

  function automatic logic [4:0] obs_ctl(input logic sel);
    if (sel) return {pc_write_b, if_id_write_b, stall_b, if_id_flush_b, halted_b};
    return {pc_write_a, if_id_write_a, stall_a, if_id_flush_a, halted_a};
  endfunction

  function automatic logic [15:0] obs_cnt(input logic sel);
    if (sel) return 16'(stall_cnt_b);
    return stall_cnt_a;
  endfunction

  function automatic step_t mk(input logic r, v, input logic [3:0] op, rs, rt, rd,
                               input logic mr, rdy, br, sel, input logic [4:0] ctl,
                               input logic [15:0] cnt);
    step_t s;
    s.r = r; s.v = v; s.op = op; s.rs = rs; s.rt = rt; s.rd = rd;
    s.mr = mr; s.rdy = rdy; s.br = br; s.sel = sel; s.ctl = ctl; s.cnt = cnt;
    return s;
  endfunction

  // Load to R3 in ID/EX while IF/ID reads R3.
  function automatic step_t hz(input logic sel, input logic [4:0] ctl, input logic [15:0] cnt,
                               input logic r = 1'b0, input logic rdy = 1'b1, input logic br = 1'b0);
    return mk(r, 1'b1, OP_ADD, 4'd3, 4'd5, 4'd3, 1'b1, rdy, br, sel, ctl, cnt);
  endfunction

  function automatic step_t idle(input logic sel, input logic [4:0] ctl, input logic [15:0] cnt);
    return mk(1'b0, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, sel, ctl, cnt);
  endfunction

  function automatic step_t hlt(input logic sel, input logic [4:0] ctl, input logic [15:0] cnt,
                                input logic br = 1'b0, input logic rdy = 1'b1, input logic r = 1'b0);
    return mk(r, 1'b1, OP_HLT, 4'd1, 4'd2, 4'd0, 1'b0, rdy, br, sel, ctl, cnt);
  endfunction

  task automatic apply(input step_t s);
    exp_t e;
    rst = s.r; if_id_valid = s.v; if_id_opcode = s.op; if_id_rs = s.rs; if_id_rt = s.rt;
    id_ex_rd = s.rd; id_ex_memread = s.mr; mem_ready = s.rdy; branch_taken = s.br;
    e.sel = s.sel; e.ctl = s.ctl; e.cnt = s.cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; if_id_valid = 1'b0; if_id_opcode = OP_NOP; if_id_rs = '0; if_id_rt = '0;
    id_ex_rd = '0; id_ex_memread = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(idle(A, C_RUN, 16'd0));
    st.push_back(idle(B, C_RUN, 16'd0));
    st.push_back(hz(B, C_STALL, 16'd0));
    st.push_back(hz(B, C_STALL, 16'd1, 1'b1));
    st.push_back(idle(B, C_RUN, 16'd0));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL reset[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL reset[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lat1();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hz(A, C_STALL, 16'd0));
    st.push_back(idle(A, C_RUN, 16'd1));
    st.push_back(idle(A, C_RUN, 16'd1));
    st.push_back(hz(A, C_STALL, 16'd1));
    st.push_back(mk(1'b0, 1'b1, OP_ADD, 4'd5, 4'd6, 4'd5, 1'b1, 1'b1, 1'b0, A, C_STALL, 16'd2));
    st.push_back(idle(A, C_RUN, 16'd3));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL lat1[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL lat1[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lat3();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hz(B, C_STALL, 16'd0));
    st.push_back(hz(B, C_STALL, 16'd1));
    st.push_back(hz(B, C_STALL, 16'd2));
    st.push_back(idle(B, C_RUN, 16'd3));
    st.push_back(mk(1'b0, 1'b1, OP_LW, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, B, C_RUN, 16'd3));
    st.push_back(mk(1'b0, 1'b1, OP_ADD, 4'd1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0, B, C_STALL, 16'd3));
    st.push_back(idle(B, C_STALL, 16'd4));
    st.push_back(idle(B, C_STALL, 16'd5));
    st.push_back(idle(B, C_RUN, 16'd6));
    st.push_back(mk(1'b0, 1'b0, OP_ADD, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, B, C_RUN, 16'd6));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL lat3[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL lat3[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hlt(A, C_STALL, 16'd0));
    for (int k = 0; k < 20; k++)
      st.push_back(mk(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      A, C_HALT, 16'(k + 1)));
    st.push_back(hlt(A, C_HALT, 16'd21, 1'b0, 1'b1, 1'b1));
    st.push_back(idle(A, C_RUN, 16'd0));
    st.push_back(idle(B, C_RUN, 16'd0));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL halt[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL halt[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_branch();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hlt(A, C_FLUSH, 16'd0, 1'b1));
    st.push_back(idle(A, C_RUN, 16'd0));
    st.push_back(idle(B, C_RUN, 16'd0));
    st.push_back(hz(B, C_STALL, 16'd0));
    st.push_back(hz(B, C_FLUSH, 16'd1, 1'b0, 1'b1, 1'b1));
    st.push_back(idle(B, C_RUN, 16'd1));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL hltbr[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL hltbr[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_freeze();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hz(B, C_STALL, 16'd0));
    for (int k = 0; k < 5; k++) st.push_back(hz(B, C_FREEZE, 16'd1, 1'b0, 1'b0));
    st.push_back(hz(B, C_STALL, 16'd1));
    st.push_back(hz(B, C_STALL, 16'd2));
    st.push_back(idle(B, C_RUN, 16'd3));
    st.push_back(hlt(B, C_FREEZE, 16'd3, 1'b0, 1'b0));
    st.push_back(idle(B, C_RUN, 16'd3));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL freeze[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL freeze[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    step_t st[$];
    exp_t e;
    do_reset();
    st.push_back(hlt(B, C_STALL, 16'd0));
    for (int k = 1; k <= 20; k++) st.push_back(idle(B, C_HALT, 16'((k > 15) ? 15 : k)));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl(e.sel) !== e.ctl) begin
        errors++; $display("FAIL sat[%0d] ctl got %b want %b", i, obs_ctl(e.sel), e.ctl);
      end
      checks++;
      if (obs_cnt(e.sel) !== e.cnt) begin
        errors++; $display("FAIL sat[%0d] cnt got %0d want %0d", i, obs_cnt(e.sel), e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lat1();
    test_lat3();
    test_halt();
    test_halt_branch();
    test_mem_freeze();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
